// File: rtl/hash_drbg_pkg.sv
// rtl/hash_drbg_pkg.sv - shared types and width helpers for the hash_drbg keystream buffer
package hash_drbg_pkg;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_QUIET = 2'd1,
    REQ_REQ   = 2'd2,
    REQ_WAIT  = 2'd3
  } req_state_t;

  function automatic int slices_per_block(input int w_in, input int w_out);
    return w_in / w_out;
  endfunction

  function automatic int slice_idx_w(input int w_in, input int w_out);
    return (w_in / w_out > 1) ? $clog2(w_in / w_out) : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hash_drbg_keystream_buffer_req_ctrl.sv
// rtl/hash_drbg_keystream_buffer_req_ctrl.sv - request FSM: waits for a quiet generator, asks for one block, accepts it
module hash_drbg_req_ctrl
  import hash_drbg_pkg::*;
#(
  parameter int QUIET_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic space_available,
  input  logic generator_busy,
  input  logic data_in_valid,
  output logic need_next,
  output logic write_en
);

  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

  req_state_t state;
  logic [7:0] quiet_cnt;

  // Only a block answering our own request is accepted; stray pulses are dropped.
  assign write_en = (state == REQ_WAIT) && data_in_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= REQ_IDLE;
      quiet_cnt <= '0;
      need_next <= 1'b0;
    end else begin
      need_next <= 1'b0;
      case (state)
        REQ_IDLE: begin
          if (space_available) begin
            state     <= REQ_QUIET;
            quiet_cnt <= '0;
          end
        end
        REQ_QUIET: begin
          if (generator_busy) begin
            quiet_cnt <= '0;
          end else begin
            quiet_cnt <= quiet_cnt + 8'd1;
            if (quiet_cnt == QUIET_LAST) begin
              state     <= REQ_REQ;
              need_next <= 1'b1;
            end
          end
        end
        REQ_REQ:  state <= REQ_WAIT;
        REQ_WAIT: begin
          if (data_in_valid) state <= REQ_IDLE;
        end
        default:  state <= REQ_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hash_drbg_keystream_buffer.sv
// rtl/hash_drbg_keystream_buffer.sv - DEPTH-block keystream ring, one slice per active-video H edge
module hash_drbg_keystream_buffer
  import hash_drbg_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 256,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int DEPTH          = 2,
  parameter int QUIET_CYCLES   = 8,
  parameter int ALIGN_ON_VSYNC = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          H,
  input  logic                          V,
  input  logic [DATA_WIDTH_IN-1:0]      data_in,
  input  logic                          data_in_valid,
  input  logic                          generator_busy,
  output logic                          need_next,
  output logic [DATA_WIDTH_OUT-1:0]     data_out,
  output logic                          data_out_valid,
  output logic                          underflow,
  output logic [fill_w(DEPTH)-1:0]      fill_level
);

  localparam int SPB = slices_per_block(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam int SIW = slice_idx_w(DATA_WIDTH_IN, DATA_WIDTH_OUT);
  localparam int PW  = ptr_w(DEPTH);
  localparam int FW  = fill_w(DEPTH);

  localparam logic [SIW-1:0] SI_LAST  = SIW'(SPB - 1);
  localparam logic [SIW-1:0] SI_ONE   = SIW'(1);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [FW-1:0]  CNT_ONE  = FW'(1);
  localparam logic [FW-1:0]  CNT_FULL = FW'(DEPTH);

  logic [DATA_WIDTH_IN-1:0] mem [DEPTH];
  logic [PW-1:0]            wp, rp;
  logic [SIW-1:0]           si;
  logic [FW-1:0]            count, count_next;
  logic                     h_q, h_qq, v_q, v_qq;
  logic                     h_rise, v_rise, demand, consume, starve, align, release_blk;
  logic                     write_en, space_available;
  logic [DATA_WIDTH_IN-1:0] rd_blk;
  logic [DATA_WIDTH_OUT-1:0] rd_slice;

  assign space_available = (count != CNT_FULL);

  hash_drbg_req_ctrl #(
    .QUIET_CYCLES (QUIET_CYCLES)
  ) u_req_ctrl (
    .clk             (clk),
    .reset           (reset),
    .space_available (space_available),
    .generator_busy  (generator_busy),
    .data_in_valid   (data_in_valid),
    .need_next       (need_next),
    .write_en        (write_en)
  );

  // Edges are taken between two registered copies so that the V level used to
  // gate a consume is sampled in the same cycle as the H edge it qualifies.
  assign h_rise  = h_q & ~h_qq;
  assign v_rise  = v_q & ~v_qq;
  assign demand  = h_rise & ~v_q;
  assign consume = demand && (count != '0);
  assign starve  = demand && (count == '0);
  assign align   = (ALIGN_ON_VSYNC != 0) && v_rise && (si != '0);
  assign release_blk = (consume && (si == SI_LAST)) || align;

  assign rd_blk   = mem[rp];
  assign rd_slice = rd_blk[int'(si) * DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
  assign fill_level = count;

  always_comb begin
    count_next = count;
    if (write_en && !release_blk)      count_next = count + CNT_ONE;
    else if (!write_en && release_blk) count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (write_en) mem[wp] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q            <= 1'b0;
      h_qq           <= 1'b0;
      v_q            <= 1'b0;
      v_qq           <= 1'b0;
      wp             <= '0;
      rp             <= '0;
      si             <= '0;
      count          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      h_q            <= H;
      h_qq           <= h_q;
      v_q            <= V;
      v_qq           <= v_q;
      data_out_valid <= 1'b0;
      underflow      <= 1'b0;
      count          <= count_next;
      if (write_en) wp <= wp + PTR_ONE;
      if (consume) begin
        data_out       <= rd_slice;
        data_out_valid <= 1'b1;
        if (si == SI_LAST) begin
          si <= '0;
          rp <= rp + PTR_ONE;
        end else begin
          si <= si + SI_ONE;
        end
      end else if (starve) begin
        underflow <= 1'b1;
      end else if (align) begin
        si <= '0;
        rp <= rp + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hash_drbg_keystream_buffer.sv
// tb/tb_hash_drbg_keystream_buffer.sv - self-checking bench for hash_drbg_keystream_buffer
module tb_hash_drbg_keystream_buffer;

  localparam int W_IN  = 256;
  localparam int W_OUT = 8;
  localparam int SPB   = W_IN / W_OUT;
  localparam int DEPTH = 2;
  localparam int QUIET = 8;
  localparam int FW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             H = 1'b0;
  logic             V = 1'b0;
  logic [W_IN-1:0]  data_in = '0;
  logic             data_in_valid = 1'b0;
  logic             generator_busy = 1'b0;
  logic             need_next;
  logic [W_OUT-1:0] data_out;
  logic             data_out_valid;
  logic             underflow;
  logic [FW-1:0]    fill_level;

  hash_drbg_keystream_buffer #(
    .DATA_WIDTH_IN  (W_IN),
    .DATA_WIDTH_OUT (W_OUT),
    .DEPTH          (DEPTH),
    .QUIET_CYCLES   (QUIET),
    .ALIGN_ON_VSYNC (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .H              (H),
    .V              (V),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .generator_busy (generator_busy),
    .need_next      (need_next),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .underflow      (underflow),
    .fill_level     (fill_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  int served = 0;
  logic [7:0] mq[$];
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) if (need_next) req_count = req_count + 1;

  typedef struct {
    logic       v;
    logic       exp_valid;
    logic       exp_uf;
    logic [7:0] exp_data;
    int         exp_fill;
  } vec_t;
  vec_t vecs[SPB + 1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_fill();
    return (mq.size() + SPB - 1) / SPB;
  endfunction

  task automatic pulse_h(input logic v_lvl, output logic sv, output logic su, output logic [7:0] dat);
    sv = 1'b0;
    su = 1'b0;
    V = v_lvl;
    H = 1'b1;
    tick();
    H = 1'b0;
    sv |= data_out_valid;
    su |= underflow;
    repeat (3) begin
      tick();
      sv |= data_out_valid;
      su |= underflow;
    end
    dat = data_out;
    V = 1'b0;
  endtask

  task automatic consume_chk(input string tag);
    logic sv, su;
    logic [7:0] dat, exp;
    logic exp_uf;
    exp_uf = (mq.size() == 0);
    exp = exp_uf ? last_data : mq.pop_front();
    pulse_h(1'b0, sv, su, dat);
    chk({tag, "_valid"}, sv, !exp_uf);
    chk({tag, "_underflow"}, su, exp_uf);
    chk({tag, "_data"}, dat, exp);
    chk({tag, "_fill"}, fill_level, model_fill());
    last_data = exp;
  endtask

  task automatic wait_pending(input string tag);
    int n;
    n = 0;
    while (req_count <= served && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_request_seen"}, req_count > served, 1);
  endtask

  task automatic deliver(input logic [W_IN-1:0] blk);
    chk("one_outstanding_request", req_count - served, 1);
    chk("no_request_when_full", model_fill() < DEPTH, 1);
    tick();
    repeat ($urandom_range(0, 2)) tick();
    data_in = blk;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    served++;
    for (int k = 0; k < SPB; k++) mq.push_back(blk[k*W_OUT +: W_OUT]);
  endtask

  function automatic logic [W_IN-1:0] rand_blk();
    logic [W_IN-1:0] b;
    for (int k = 0; k < W_IN / 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  initial begin
    logic [W_IN-1:0] blk;
    logic sv, su;
    logic [7:0] dat;
    int n, seen;

    for (int i = 0; i < SPB; i++)
      vecs[i] = '{v: 1'b0, exp_valid: 1'b1, exp_uf: 1'b0, exp_data: 8'(i),
                  exp_fill: (i == SPB - 1) ? 1 : 2};
    vecs[SPB] = '{v: 1'b1, exp_valid: 1'b0, exp_uf: 1'b0, exp_data: 8'h1F, exp_fill: 1};

    // Reset values
    repeat (3) tick();
    chk("rst_need_next", need_next, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_out_valid", data_out_valid, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_fill_level", fill_level, 0);

    // First request: IDLE->QUIET on edge 1, 8 quiet edges, visible after edge 9 (cycle 10)
    reset = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!need_next && n < 40);
    chk("first_request_edge", n, QUIET + 1);
    tick();
    chk("need_next_one_cycle", need_next, 0);

    for (int k = 0; k < SPB; k++) blk[k*W_OUT +: W_OUT] = 8'(k);
    deliver(blk);
    chk("fill_after_first_block", fill_level, 1);
    wait_pending("second");
    for (int k = 0; k < SPB; k++) blk[k*W_OUT +: W_OUT] = 8'(8'h80 + k);
    deliver(blk);
    chk("fill_after_second_block", fill_level, 2);
    seen = req_count;
    repeat (30) tick();
    chk("no_request_when_full_idle", req_count - seen, 0);

    // Table: one full block of slices, then an H edge coinciding with a V edge
    for (int i = 0; i <= SPB; i++) begin
      pulse_h(vecs[i].v, sv, su, dat);
      chk($sformatf("vec%0d_valid", i), sv, vecs[i].exp_valid);
      chk($sformatf("vec%0d_underflow", i), su, vecs[i].exp_uf);
      chk($sformatf("vec%0d_data", i), dat, vecs[i].exp_data);
      chk($sformatf("vec%0d_fill", i), fill_level, vecs[i].exp_fill);
      if (vecs[i].exp_valid) void'(mq.pop_front());
    end
    last_data = 8'h1F;

    wait_pending("refill");
    deliver(rand_blk());
    chk("fill_after_refill", fill_level, 2);

    // Alignment: 5 slices into a block, then V rises
    for (int i = 0; i < 5; i++) consume_chk($sformatf("align_pre%0d", i));
    V = 1'b1;
    repeat (3) tick();
    chk("align_fill_drop", fill_level, 1);
    while (mq.size() % SPB != 0) void'(mq.pop_front());
    V = 1'b0;
    repeat (2) tick();
    consume_chk("align_next_slice0");

    // Randomised traffic against the slice-queue model
    for (int it = 0; it < 80; it++) begin
      case ($urandom_range(0, 3))
        0, 1: consume_chk("rand");
        2: if (req_count > served) deliver(rand_blk());
        default: begin
          generator_busy = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 4)) tick();
          generator_busy = 1'b0;
        end
      endcase
    end

    // Drain, then underflow with data held, then the same pulse during blanking
    while (mq.size() > 0) consume_chk("drain");
    consume_chk("underflow_empty");
    pulse_h(1'b1, sv, su, dat);
    chk("blank_no_underflow", su, 0);
    chk("blank_no_valid", sv, 0);

    // Reset while WAIT: late data_in_valid must be ignored and quiet count restarts
    wait_pending("pre_reset");
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    data_in = rand_blk();
    data_in_valid = 1'b1;
    served = req_count;
    mq.delete();
    last_data = 8'h00;
    chk("rst_mid_data_out", data_out, 0);
    n = 0;
    do begin
      tick();
      n++;
      data_in_valid = 1'b0;
      chk($sformatf("rst_mid_fill_%0d", n), fill_level, 0);
    end while (!need_next && n < 40);
    chk("restart_request_edge", n, QUIET + 1);

    // Write into empty buffer in the same cycle as a demand: still underflow
    tick();
    blk = rand_blk();
    H = 1'b1;
    tick();
    H = 1'b0;
    data_in = blk;
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    served++;
    chk("write_demand_underflow", underflow, 1);
    chk("write_demand_no_valid", data_out_valid, 0);
    tick();
    chk("write_demand_fill", fill_level, 1);
    for (int k = 0; k < SPB; k++) mq.push_back(blk[k*W_OUT +: W_OUT]);
    consume_chk("after_write_demand");

    // Busy generator: need_next only after 8 consecutive quiet cycles
    reset = 1'b1;
    repeat (2) tick();
    generator_busy = 1'b1;
    reset = 1'b0;
    served = req_count;
    mq.delete();
    seen = req_count;
    for (int i = 0; i < 20; i++) begin
      generator_busy = (i >= 8 && i < 11) ? 1'b0 : 1'b1;
      tick();
    end
    chk("busy_no_request", req_count - seen, 0);
    generator_busy = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!need_next && n < 40);
    chk("busy_release_request_edge", n, QUIET);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_drbg_keystream_buffer.md
Name: hash_drbg_keystream_buffer

Overview:
Parametrised keystream buffer between the hash_drbg generator and the scrambler datapath. It holds DEPTH generator blocks and prefetches new blocks autonomously with a busy-quiet request handshake. On every H rising edge during active video (V low) it emits one DATA_WIDTH_OUT slice. Everything runs in the single clk domain. It adds underflow reporting, a fill-level output and optional per-frame block alignment.

Parameters:
DATA_WIDTH_IN, 256, generator block width; must be an integer multiple of DATA_WIDTH_OUT.
DATA_WIDTH_OUT, 8, keystream slice width per H edge.
DEPTH, 2, number of buffered blocks; power of two, at least 2.
QUIET_CYCLES, 8, consecutive generator_busy-low cycles required before need_next may be asserted; range 1..255.
ALIGN_ON_VSYNC, 1, when 1 a V rising edge discards the rest of a partially read block.

Ports:
clk  in  1  system clock; H, V and generator signals are synchronous to it.
reset  in  1  asynchronous, active-high reset.
H  in  1  horizontal sync level.
V  in  1  vertical blanking level; high means blanking.
data_in  in  DATA_WIDTH_IN  generator output block.
data_in_valid  in  1  data_in is valid this cycle; one-cycle pulse.
generator_busy  in  1  generator is computing.
need_next  out  1  one-cycle request for a new block.
data_out  out  DATA_WIDTH_OUT  current keystream slice.
data_out_valid  out  1  one-cycle pulse when data_out is updated.
underflow  out  1  one-cycle pulse when a slice is demanded but no data is available.
fill_level  out  $clog2(DEPTH+1)  number of valid blocks, including the one being read.

Behaviour:
- Reset values: need_next=0, data_out=0, data_out_valid=0, underflow=0, fill_level=0. All pointers, counters and the FSM are cleared and the edge-detect registers are set to 0.
- Reset mid-operation: the outstanding request is abandoned. A data_in_valid arriving after reset is ignored unless the FSM is in WAIT.
- Storage: a ring of DEPTH blocks with write pointer wp, read pointer rp, slice index si (0..DATA_WIDTH_IN/DATA_WIDTH_OUT-1) and a block count.
- Slice ordering: slice k = data_in[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT], LSB first.
- Request FSM states: IDLE, QUIET, REQ, WAIT.
  - IDLE -> QUIET when count < DEPTH; quiet counter cleared.
  - QUIET: the counter increments while generator_busy=0 and clears to 0 whenever generator_busy=1. It goes to REQ when the counter reaches QUIET_CYCLES.
  - REQ: need_next=1 for exactly this cycle, then -> WAIT.
  - WAIT: on data_in_valid the whole block is written to slot wp in that same cycle, wp increments (wrapping), and the FSM returns to IDLE. There is no timeout.
  - At most one request is outstanding at any time.
- Consume: the edge-detect register gives H_rise = H & ~H_q and V_rise = V & ~V_q, each one cycle after the input edge.
  - On H_rise with V=0 and count>0: data_out <= slice si of block rp and data_out_valid=1 on the next cycle.
  - If si is the last slice, si returns to 0, rp increments and the block is released; otherwise si increments.
  - On H_rise with V=0 and count=0: underflow=1 for one cycle, data_out holds its value, data_out_valid=0.
  - H_rise with V=1 is ignored.
- Alignment: with ALIGN_ON_VSYNC=1 and si!=0, a V_rise releases the current block and sets si to 0. If si=0 nothing changes.
- Simultaneous events:
  - Write and release in the same cycle leave count unchanged.
  - Write into an empty buffer with H_rise in the same cycle still reports underflow; the new data is first usable at the next H_rise.
  - V_rise and H_rise together: the consume is skipped because V=1.
- Full: when count=DEPTH the FSM stays in IDLE. A write never overwrites an unread block.
- fill_level equals count, registered, with the same timing as the count update.

Decomposition:
- Package hash_drbg_pkg holds the request FSM state encoding, slices-per-block and slice-index width localparam functions, and the fill_level width function.
- One sub-module, hash_drbg_req_ctrl, contains the IDLE/QUIET/REQ/WAIT FSM and the quiet counter. Its inputs are space_available, generator_busy and data_in_valid; its outputs are need_next and write_en.

Test Plan:
- Reset, then generator_busy=0 constantly -> need_next pulses on cycle 10 (1 edge-detect cycle + 8 quiet cycles + REQ). A block 0x1F..0x00 is returned -> fill_level=1, then a second request follows -> fill_level=2 and requests stop.
- With 2 blocks loaded and V=0, apply 32 H pulses -> data_out=0x00,0x01,..,0x1F with 32 data_out_valid pulses. fill_level drops to 1 after the 32nd and a new need_next follows.
- Hold generator_busy high for 20 cycles, toggling low for 3 cycles mid-way -> need_next only after 8 consecutive low cycles.
- Empty buffer with an H pulse at V=0 -> underflow pulse, data_out_valid=0, data_out unchanged. The same pulse at V=1 -> no underflow.
- ALIGN_ON_VSYNC=1, consume 5 slices, then V rises -> fill_level decrements by 1. After V falls, the next H outputs slice 0 of the following block.
- Assert reset while in WAIT, release it, then pulse data_in_valid -> no write, fill_level stays 0, and the FSM restarts the quiet count.
